result_packer_writer: RTL and testbench
=======================================

// Module: result_packer_writer
// PURPOSE
//  Downstream of the accumulate-core stage. Takes the stream of 32-bit core results
//  (valid-qualified), packs two results per 64-bit row and writes the rows to BRAM1
//  over the single-port memory I/F. Reports idle/write/done status to the controller.
// PARAMETERS
//  CNT_BIT   31   width of run_count_i and the internal result counter
//  DWIDTH_1  32   width of one core result (one lane)
//  DWIDTH_2  64   BRAM1 row width; must equal 2*DWIDTH_1
//  AWIDTH    8    BRAM1 address width
//  MEM_SIZE  256  BRAM1 depth in rows
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous reset, active-high
//  start_run_i  in   1         pulse; starts a run (ignored unless IDLE)
//  run_count_i  in   CNT_BIT   number of results to expect; sampled on start
//  result_i     in   DWIDTH_1  core result
//  valid_i      in   1         result_i qualifier; one result per high cycle
//  idle_o       out  1         state == IDLE
//  write_o      out  1         state == RUN or FLUSH
//  done_o       out  1         state == DONE (exactly one cycle)
//  err_o        out  1         sticky: valid_i outside RUN/extra result/addr wrap
//  addr_b1_o    out  AWIDTH    BRAM1 address
//  ce_b1_o      out  1         BRAM1 chip enable
//  we_b1_o      out  1         BRAM1 write enable
//  d_b1_o       out  DWIDTH_2  BRAM1 write data
//  checksum_o   out  32        only with RESULT_CHECKSUM_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; idle_o=1; all other outputs, counters, lane buffer = 0.
//  All outputs registered. Reset mid-run aborts at the next edge: no further writes.
//  FSM: IDLE -start_run_i-> RUN (run_count_i!=0) or DONE (run_count_i==0, no write);
//    RUN -last result, even count-> DONE after its write cycle;
//    RUN -last result, odd count-> FLUSH -> DONE; DONE -> IDLE unconditionally.
//  Packing: 1st result of a pair -> low lane d[31:0] (held in buffer);
//    2nd -> high lane d[63:32]. Pair completes at valid_i cycle n ->
//    ce=we=1, addr, d driven at cycle n+1 for exactly one cycle.
//  Odd count: FLUSH writes final row with high lane = 0, one cycle after last result.
//  Address: starts 0 each run, +1 after each write; row k at addr k.
//    After MEM_SIZE-1 wraps to 0 and sets err_o; writing continues.
//  done_o rises the cycle after the final write (ce=we=1) cycle; never same cycle.
//  No backpressure: valid_i may be high every cycle in RUN; max one write per 2 results.
//  valid_i in IDLE/DONE, or beyond run_count_i: dropped, err_o set.
//  start_run_i while not IDLE: ignored, no error. err_o cleared on accepted start.
//  Outside write cycles ce_b1_o=we_b1_o=0, d_b1_o=0, addr_b1_o holds.
// CONFIGURATION
//  RESULT_CHECKSUM_EN defined: checksum_o = 32-bit wrapping sum of every result
//    accepted this run; cleared on accepted start, stable from done_o until next start.
//  Undefined: checksum_o port and adder absent; all other behaviour identical.
// TESTING
//  count=4, results 1,2,3,4 back-to-back -> addr0=0x00000002_00000001,
//    addr1=0x00000004_00000003; done_o 1 cycle after 2nd write; idle next.
//  count=3, results 5,6,7 with gaps -> addr0=0x00000006_00000005, FLUSH addr1=0x00000000_00000007.
//  count=0 start -> done_o next cycle, ce_b1_o never high, then idle_o.
//  count=514, MEM_SIZE=256 -> row 256 written at addr 0, err_o=1, done still reached.
//  rst high mid-run after 3 results -> next cycle all outputs reset values, no further writes;
//    new start runs clean from addr 0.
//  CHECKSUM_EN, count=2, 0xFFFFFFFF,0x2 -> checksum_o=0x00000001 at done_o.

Source files
------------

// File: rtl/result_packer_writer_if.sv
// -----------------------------------------------------------------------------
// result_packer_writer_if
//   Single-port BRAM1 write bus between the result packer/writer and the
//   memory. One row write per cycle in which ce_b1 and we_b1 are both high.
//
//   Signals
//     addr_b1  AWIDTH    row address
//     ce_b1    1         chip enable
//     we_b1    1         write enable
//     d_b1     DWIDTH_2  row write data
//
//   Modports
//     master   the writer (drives every signal)
//     slave    the memory (samples every signal)
// -----------------------------------------------------------------------------
interface result_packer_writer_if #(
  parameter int AWIDTH   = 8,
  parameter int DWIDTH_2 = 64
);

  logic [AWIDTH-1:0]   addr_b1;
  logic                ce_b1;
  logic                we_b1;
  logic [DWIDTH_2-1:0] d_b1;

  modport master (
    output addr_b1,
    output ce_b1,
    output we_b1,
    output d_b1
  );

  modport slave (
    input addr_b1,
    input ce_b1,
    input we_b1,
    input d_b1
  );

endinterface

// File: rtl/result_packer_writer.sv
// -----------------------------------------------------------------------------
// result_packer_writer
//   Sits downstream of the accumulate-core stage. Collects the valid-qualified
//   stream of DWIDTH_1-bit core results, packs two results per DWIDTH_2-bit row
//   (first result in the low lane, second in the high lane) and writes the rows
//   to BRAM1, row k at address k. An odd final result is written in a FLUSH
//   cycle with the high lane zeroed. Status flags tell the controller whether
//   the block is idle, writing, or has just finished a run.
//
//   Optional feature: define RESULT_CHECKSUM_EN to add checksum_o, the 32-bit
//   wrapping sum of all results accepted in the current run.
//
//   Ports
//     clk          in   clock
//     rst          in   synchronous reset, active-high
//     start_run_i  in   start pulse, honoured only when idle
//     run_count_i  in   number of results in the run, sampled on start
//     result_i     in   core result
//     valid_i      in   result_i qualifier, one result per high cycle
//     idle_o       out  block is idle
//     write_o      out  run in progress (RUN or FLUSH)
//     done_o       out  one-cycle pulse after the final row write
//     err_o        out  sticky: stray/extra result or address wrap overwrite
//     checksum_o   out  run checksum (RESULT_CHECKSUM_EN only)
//     b1           BRAM1 write bus (master side)
//
//   All outputs are registered. No backpressure: a result may arrive every
//   cycle during RUN, which produces at most one row write per two results.
// -----------------------------------------------------------------------------
module result_packer_writer #(
  parameter int CNT_BIT  = 31,
  parameter int DWIDTH_1 = 32,
  parameter int DWIDTH_2 = 64,   // must equal 2*DWIDTH_1
  parameter int AWIDTH   = 8,
  parameter int MEM_SIZE = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_run_i,
  input  logic [CNT_BIT-1:0]  run_count_i,
  input  logic [DWIDTH_1-1:0] result_i,
  input  logic                valid_i,
  output logic                idle_o,
  output logic                write_o,
  output logic                done_o,
  output logic                err_o,
`ifdef RESULT_CHECKSUM_EN
  output logic [31:0]         checksum_o,
`endif
  result_packer_writer_if.master b1
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Run bookkeeping
  logic [CNT_BIT-1:0]  count_q;      // results expected this run
  logic [CNT_BIT-1:0]  accepted_q;   // results accepted so far
  logic [DWIDTH_1-1:0] lane_q;       // low lane waiting for its partner
  logic                lane_full_q;  // lane_q holds a result
  logic [AWIDTH-1:0]   wr_addr_q;    // address of the next row write
  logic                wrapped_q;    // address counter has rolled over

  // Per-cycle decisions
  logic                start_acc;
  logic                accept;
  logic                last;
  logic                issue_write;
  logic                rollover;
  logic [DWIDTH_2-1:0] row_data;

  // Registered-status inputs
  logic idle_d, write_d, done_d;

  // ---------------------------------------------------------------------------
  // Datapath decisions
  // ---------------------------------------------------------------------------
  assign start_acc = (state_q == S_IDLE) && start_run_i;

  // A result is taken only while running and only up to the programmed count;
  // anything else on valid_i is dropped and flagged.
  assign accept    = (state_q == S_RUN) && valid_i && (accepted_q != count_q);
  assign last      = accept && ((accepted_q + CNT_BIT'(1)) == count_q);

  // A row goes out when a pair completes, or immediately for an odd final
  // result (that write cycle is the FLUSH state).
  assign issue_write = accept && (lane_full_q || last);

  assign row_data = lane_full_q ? {result_i, lane_q}
                                : {{DWIDTH_1{1'b0}}, result_i};

  assign rollover = (wr_addr_q == AWIDTH'(MEM_SIZE - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked assignment is non-blocking so all flops sample the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_run_i) begin
          state_d = (run_count_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // Odd count: the final result has no partner, so spend one FLUSH
        // cycle writing it. Even count: stay in RUN for the final write
        // cycle, then leave once all results are in.
        if (last && !lane_full_q) begin
          state_d = S_FLUSH;
        end else if (accepted_q == count_q) begin
          state_d = S_DONE;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  // Decoded from the next state so the status flops line up with state_q.
  always_comb begin
    idle_d  = (state_d == S_IDLE);
    write_d = (state_d == S_RUN) || (state_d == S_FLUSH);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_o  <= 1'b1;
      write_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      idle_o  <= idle_d;
      write_o <= write_d;
      done_o  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Run counters and lane buffer
  // ---------------------------------------------------------------------------
  // NOTE: the lane buffer is a single register, not a memory array, so it is
  // reset like any other flop and a reset mid-run leaves no stale half-row.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      accepted_q  <= '0;
      lane_q      <= '0;
      lane_full_q <= 1'b0;
    end else if (start_acc) begin
      count_q     <= run_count_i;
      accepted_q  <= '0;
      lane_q      <= '0;
      lane_full_q <= 1'b0;
    end else if (accept) begin
      accepted_q <= accepted_q + CNT_BIT'(1);
      if (lane_full_q) begin
        lane_q      <= '0;
        lane_full_q <= 1'b0;
      end else if (!last) begin
        lane_q      <= result_i;
        lane_full_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row address counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      wrapped_q <= 1'b0;
    end else if (start_acc) begin
      wr_addr_q <= '0;
      wrapped_q <= 1'b0;
    end else if (issue_write) begin
      wr_addr_q <= rollover ? '0 : wr_addr_q + AWIDTH'(1);
      if (rollover) begin
        wrapped_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BRAM1 write port: one-cycle strobes, data zeroed and address held between
  // writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      b1.addr_b1 <= '0;
      b1.ce_b1   <= 1'b0;
      b1.we_b1   <= 1'b0;
      b1.d_b1    <= '0;
    end else begin
      b1.ce_b1 <= issue_write;
      b1.we_b1 <= issue_write;
      b1.d_b1  <= issue_write ? row_data : '0;
      if (issue_write) begin
        b1.addr_b1 <= wr_addr_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error. Cleared by an accepted start; set by any result that is not
  // accepted and by a write that lands on an already-used address after the
  // counter has rolled over.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= (err_o && !start_acc)
             || (valid_i && !accept)
             || (issue_write && wrapped_q);
    end
  end

`ifdef RESULT_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Run checksum: wrapping sum of accepted results, stable after the run until
  // the next accepted start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_o <= '0;
    end else if (start_acc) begin
      checksum_o <= '0;
    end else if (accept) begin
      checksum_o <= checksum_o + 32'(result_i);
    end
  end
`endif

endmodule

// File: tb/tb_result_packer_writer.sv
// -----------------------------------------------------------------------------
// tb_result_packer_writer
//   Directed bench for result_packer_writer. A transaction-level model keeps
//   the run window, the list of expected row writes keyed by cycle and the
//   sticky-error events; a single compare process checks every DUT output
//   against it each cycle. Hand-computed literals pin the key rows, addresses
//   and done timing of each scenario.
// -----------------------------------------------------------------------------
module tb_result_packer_writer;

  localparam int CNT_BIT  = 31;
  localparam int DWIDTH_1 = 32;
  localparam int DWIDTH_2 = 64;
  localparam int AWIDTH   = 8;
  localparam int MEM_SIZE = 256;
  localparam int BIG      = 32'h3fff_ffff;

  logic                clk;
  logic                rst;
  logic                start_run_i;
  logic [CNT_BIT-1:0]  run_count_i;
  logic [DWIDTH_1-1:0] result_i;
  logic                valid_i;
  logic                idle_o;
  logic                write_o;
  logic                done_o;
  logic                err_o;
`ifdef RESULT_CHECKSUM_EN
  logic [31:0]         checksum_o;
`endif

  result_packer_writer_if #(.AWIDTH(AWIDTH), .DWIDTH_2(DWIDTH_2)) b1_bus ();

  result_packer_writer #(
    .CNT_BIT (CNT_BIT),
    .DWIDTH_1(DWIDTH_1),
    .DWIDTH_2(DWIDTH_2),
    .AWIDTH  (AWIDTH),
    .MEM_SIZE(MEM_SIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_run_i(start_run_i),
    .run_count_i(run_count_i),
    .result_i   (result_i),
    .valid_i    (valid_i),
    .idle_o     (idle_o),
    .write_o    (write_o),
    .done_o     (done_o),
    .err_o      (err_o),
`ifdef RESULT_CHECKSUM_EN
    .checksum_o (checksum_o),
`endif
    .b1         (b1_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: a run occupies cycles run_lo..run_end (not idle); done_at is its
  // done cycle (-1 if aborted). Expected writes and error events are keyed by
  // the cycle on which they must be visible.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [AWIDTH-1:0]   addr;
    logic [DWIDTH_2-1:0] data;
  } wr_t;

  wr_t  exp_wr [int];
  bit   err_set[int];
  bit   err_clr[int];
  bit   rst_ev [int];

  int          run_lo  = BIG;
  int          run_end = -1;
  int          done_at = -1;
  int          run_cnt = 0;
  int          n_acc   = 0;
  int          row     = 0;
  logic [31:0] low_lane = '0;
  logic [31:0] m_sum    = '0;

  function automatic bit m_busy(input int c);
    return (c >= run_lo) && (c <= run_end);
  endfunction

  task automatic m_start(input int c, input int count);
    if (!m_busy(c)) begin
      run_lo  = c + 1;
      run_cnt = count;
      n_acc   = 0;
      row     = 0;
      m_sum   = '0;
      err_clr[c + 1] = 1'b1;
      if (count == 0) begin
        run_end = c + 1;
        done_at = c + 1;
      end else begin
        run_end = BIG;
        done_at = BIG;
      end
    end
  endtask

  task automatic m_valid(input int c, input logic [31:0] d);
    wr_t w;
    if (m_busy(c) && (n_acc < run_cnt)) begin
      n_acc++;
      m_sum = m_sum + d;
      if ((n_acc % 2 == 1) && (n_acc != run_cnt)) begin
        low_lane = d;
      end else begin
        w.addr = AWIDTH'(row % MEM_SIZE);
        w.data = (n_acc % 2 == 0) ? {d, low_lane} : {32'h0, d};
        exp_wr[c + 1] = w;
        if (row >= MEM_SIZE) err_set[c + 1] = 1'b1;
        row++;
      end
      if (n_acc == run_cnt) begin
        run_end = c + 2;
        done_at = c + 2;
      end
    end else begin
      err_set[c + 1] = 1'b1;
    end
  endtask

  task automatic m_reset(input int c);
    exp_wr.delete(c + 1);
    err_set.delete(c + 1);
    rst_ev[c + 1] = 1'b1;
    if (m_busy(c) || run_lo > c) begin
      run_end = c;
      if (done_at > c) done_at = -1;
      run_cnt = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  bit                chk_en = 1'b0;
  bit                m_err  = 1'b0;
  logic [AWIDTH-1:0] m_addr = '0;
  int                log_cyc [$];
  logic [AWIDTH-1:0] log_addr[$];
  logic [63:0]       log_data[$];
  int                done_q  [$];

  always @(negedge clk) begin
    if (chk_en) begin
      bit   wexp, exp_done;
      wr_t  w;
      if (rst_ev.exists(cyc)) begin
        m_err  = 1'b0;
        m_addr = '0;
      end
      if (err_clr.exists(cyc)) m_err = 1'b0;
      if (err_set.exists(cyc)) m_err = 1'b1;
      exp_done = (cyc == done_at);
      wexp     = exp_wr.exists(cyc);
      w        = wexp ? exp_wr[cyc] : '0;
      if (wexp) m_addr = w.addr;

      check("idle_o",  64'(idle_o),  64'(!m_busy(cyc)));
      check("write_o", 64'(write_o), 64'(m_busy(cyc) && !exp_done));
      check("done_o",  64'(done_o),  64'(exp_done));
      check("err_o",   64'(err_o),   64'(m_err));
      check("ce_b1",   64'(b1_bus.ce_b1),   64'(wexp));
      check("we_b1",   64'(b1_bus.we_b1),   64'(wexp));
      check("addr_b1", 64'(b1_bus.addr_b1), 64'(m_addr));
      check("d_b1",    b1_bus.d_b1,         w.data);
`ifdef RESULT_CHECKSUM_EN
      if (exp_done) check("checksum_o", 64'(checksum_o), 64'(m_sum));
`endif
      if (b1_bus.ce_b1 === 1'b1) begin
        log_cyc.push_back(cyc);
        log_addr.push_back(b1_bus.addr_b1);
        log_data.push_back(b1_bus.d_b1);
      end
      if (done_o === 1'b1) done_q.push_back(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+#1; each covers one cycle)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input int cnt, input bit v,
                       input logic [31:0] d);
    start_run_i = s;
    run_count_i = CNT_BIT'(cnt);
    valid_i     = v;
    result_i    = d;
    if (s) m_start(cyc, cnt);
    if (v) m_valid(cyc, d);
    tick();
    start_run_i = 1'b0;
    run_count_i = '0;
    valid_i     = 1'b0;
    result_i    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 32'h0);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    m_reset(cyc);
    tick();
    rst = 1'b0;
  endtask

  function automatic int last_done();
    return (done_q.size() != 0) ? done_q[done_q.size() - 1] : -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    int s_cyc;

    rst         = 1'b1;
    start_run_i = 1'b0;
    run_count_i = '0;
    valid_i     = 1'b0;
    result_i    = '0;
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_idle",  64'(idle_o),         64'd1);
    check("rst_write", 64'(write_o),        64'd0);
    check("rst_done",  64'(done_o),         64'd0);
    check("rst_err",   64'(err_o),          64'd0);
    check("rst_ce",    64'(b1_bus.ce_b1),   64'd0);
    check("rst_addr",  64'(b1_bus.addr_b1), 64'd0);
    check("rst_d",     b1_bus.d_b1,         64'd0);
    tick();

    // count=4, back-to-back; a start pulse mid-run must be ignored
    base = log_data.size();
    drive(1'b1, 4, 1'b0, 32'h0);
    drive(1'b0, 0, 1'b1, 32'd1);
    drive(1'b1, 4, 1'b1, 32'd2);
    drive(1'b0, 0, 1'b1, 32'd3);
    drive(1'b0, 0, 1'b1, 32'd4);
    idle(4);
    check("t1_n_writes", 64'(log_data.size() - base), 64'd2);
    if (log_data.size() >= base + 2) begin
      check("t1_row0_data", log_data[base],     64'h00000002_00000001);
      check("t1_row0_addr", 64'(log_addr[base]),     64'd0);
      check("t1_row1_data", log_data[base + 1], 64'h00000004_00000003);
      check("t1_row1_addr", 64'(log_addr[base + 1]), 64'd1);
      check("t1_done_cycle", 64'(last_done()), 64'(log_cyc[base + 1] + 1));
    end

    // count=3 with gaps, odd tail flushed; then a stray result while idle
    base = log_data.size();
    drive(1'b1, 3, 1'b0, 32'h0);
    drive(1'b0, 0, 1'b1, 32'd5);
    idle(1);
    drive(1'b0, 0, 1'b1, 32'd6);
    idle(2);
    drive(1'b0, 0, 1'b1, 32'd7);
    s_cyc = cyc;
    idle(3);
    check("t2_n_writes", 64'(log_data.size() - base), 64'd2);
    if (log_data.size() >= base + 2) begin
      check("t2_row0_data",  log_data[base],     64'h00000006_00000005);
      check("t2_flush_data", log_data[base + 1], 64'h00000000_00000007);
      check("t2_flush_addr", 64'(log_addr[base + 1]), 64'd1);
      check("t2_flush_cycle", 64'(log_cyc[base + 1]), 64'(s_cyc));
    end
    drive(1'b0, 0, 1'b1, 32'd99);
    @(negedge clk);
    check("t2_stray_err", 64'(err_o), 64'd1);
    tick();

    // count=0: done next cycle, no write, error cleared by the start
    base  = log_data.size();
    s_cyc = cyc;
    drive(1'b1, 0, 1'b0, 32'h0);
    @(negedge clk);
    check("t3_done", 64'(done_o), 64'd1);
    check("t3_err_cleared", 64'(err_o), 64'd0);
    tick();
    idle(2);
    check("t3_done_cycle", 64'(last_done()), 64'(s_cyc + 1));
    check("t3_no_write", 64'(log_data.size() - base), 64'd0);

    // count=514: 257 rows, row 256 wraps to address 0 and flags an error
    base = log_data.size();
    drive(1'b1, 514, 1'b0, 32'h0);
    for (int i = 1; i <= 514; i++) drive(1'b0, 0, 1'b1, 32'(i));
    idle(4);
    check("t4_n_writes", 64'(log_data.size() - base), 64'd257);
    if (log_data.size() >= base + 257) begin
      check("t4_row255_addr", 64'(log_addr[base + 255]), 64'd255);
      check("t4_row255_data", log_data[base + 255], 64'h00000200_000001ff);
      check("t4_row256_addr", 64'(log_addr[base + 256]), 64'd0);
      check("t4_row256_data", log_data[base + 256], 64'h00000202_00000201);
      check("t4_done_cycle", 64'(last_done()), 64'(log_cyc[base + 256] + 1));
    end
    @(negedge clk);
    check("t4_err", 64'(err_o), 64'd1);
    tick();

    // Reset after three results of a six-result run, then a clean run
    base = log_data.size();
    drive(1'b1, 6, 1'b0, 32'h0);
    drive(1'b0, 0, 1'b1, 32'd10);
    drive(1'b0, 0, 1'b1, 32'd11);
    drive(1'b0, 0, 1'b1, 32'd12);
    do_rst();
    @(negedge clk);
    check("t5_idle_after_rst", 64'(idle_o), 64'd1);
    check("t5_addr_after_rst", 64'(b1_bus.addr_b1), 64'd0);
    tick();
    idle(3);
    check("t5_writes_before_rst", 64'(log_data.size() - base), 64'd1);
    drive(1'b1, 2, 1'b0, 32'h0);
    drive(1'b0, 0, 1'b1, 32'd20);
    drive(1'b0, 0, 1'b1, 32'd21);
    idle(4);
    check("t5_n_writes", 64'(log_data.size() - base), 64'd2);
    if (log_data.size() >= base + 2) begin
      check("t5_new_addr", 64'(log_addr[base + 1]), 64'd0);
      check("t5_new_data", log_data[base + 1], 64'h00000015_00000014);
    end

    // Wrapping sum across a full-scale result
    base = log_data.size();
    drive(1'b1, 2, 1'b0, 32'h0);
    drive(1'b0, 0, 1'b1, 32'hffff_ffff);
    drive(1'b0, 0, 1'b1, 32'h0000_0002);
    idle(4);
    if (log_data.size() >= base + 1) begin
      check("t6_row_data", log_data[base], 64'h00000002_ffffffff);
    end
`ifdef RESULT_CHECKSUM_EN
    @(negedge clk);
    check("t6_checksum", 64'(checksum_o), 64'h0000_0001);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
